boot_ctrl_regs: RTL and testbench

- Regbus-mapped boot controller that sits directly downstream of the host register bus and upstream of the CPU core.
- Holds the core in reset, latches the DRAM base and entry PC, releases the core on a START command, and stretches the release with a fixed reset pulse.
- Snoops CPU-side stores to the riscv-tests tohost address, so the host can read pass/fail and a run-cycle count without backdoor memory access.

---
 rtl/boot_ctrl_regs.sv | 158 +++++++++++++++
 tb/tb_boot_ctrl_regs.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_ctrl_regs.sv
// Register-bus boot controller: holds the CPU core in reset, latches its boot
// configuration, runs it on START and snoops tohost stores for pass/fail.
module boot_ctrl_regs #(
  parameter logic [15:0] BASE           = 16'h1000,
  parameter int unsigned RST_CYCLES     = 16,
  parameter logic [31:0] TOHOST_DEFAULT = 32'h0000_1000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  input  logic        mon_wvalid,
  input  logic [31:0] mon_waddr,
  input  logic [31:0] mon_wdata,
  output logic        core_rst_n,
  output logic [31:0] dram_base,
  output logic [31:0] entry_pc
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RSTSTR = 2'd1,
    ST_RUN    = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  localparam logic [2:0]  REG_STATUS     = 3'd0;
  localparam logic [2:0]  REG_CTRL       = 3'd1;
  localparam logic [2:0]  REG_DRAMBASE   = 3'd2;
  localparam logic [2:0]  REG_ENTRYPC    = 3'd3;
  localparam logic [2:0]  REG_CYCLES     = 3'd4;
  localparam logic [2:0]  REG_TOHOST     = 3'd5;
  localparam logic [2:0]  REG_TOHOST_VAL = 3'd6;
  localparam logic [15:0] RST_LAST       = 16'(RST_CYCLES - 1);

  state_e      state, state_nxt;
  logic        hold_reset, hold_nxt, done, pass;
  logic [31:0] cycles, tohost, tohost_val;
  logic [15:0] rst_cnt;

  logic [15:0] wr_off, rd_off;
  logic        wr_hit, rd_hit;
  logic [2:0]  wr_sel, rd_sel;
  logic        ctrl_b0_wr, hold_set, start_req, cfg_locked, tohost_hit, enter_rststr;
  logic [31:0] rd_data;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  // Window is 32 bytes; unaligned offsets decode as unmapped.
  assign wr_off = WRADDR - BASE;
  assign rd_off = RDADDR - BASE;
  assign wr_hit = WREN && (wr_off[15:5] == '0) && (wr_off[1:0] == 2'b00);
  assign rd_hit = (rd_off[15:5] == '0) && (rd_off[1:0] == 2'b00);
  assign wr_sel = wr_off[4:2];
  assign rd_sel = rd_off[4:2];

  assign ctrl_b0_wr = wr_hit && (wr_sel == REG_CTRL) && BYTEEN[0];
  assign hold_set   = ctrl_b0_wr && WDATA[0];
  assign start_req  = ctrl_b0_wr && WDATA[1];
  assign hold_nxt   = ctrl_b0_wr ? WDATA[0] : hold_reset;
  assign cfg_locked = (state == ST_RSTSTR) || (state == ST_RUN);
  assign tohost_hit = mon_wvalid && (mon_waddr == tohost) && mon_wdata[0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    unique case (state)
      ST_HOLD, ST_FIN: if (start_req && !hold_nxt) state_nxt = ST_RSTSTR;
      ST_RSTSTR:       if (rst_cnt == RST_LAST)    state_nxt = ST_RUN;
      ST_RUN:          if (tohost_hit)             state_nxt = ST_FIN;
      default:         state_nxt = ST_HOLD;
    endcase
    // Asserting HOLD_RESET overrides START and a coincident tohost hit.
    if (hold_set) state_nxt = ST_HOLD;
  end

  assign enter_rststr = (state_nxt == ST_RSTSTR) && (state != ST_RSTSTR);

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ARESETN) begin
      state      <= ST_HOLD;
      core_rst_n <= 1'b0;
      hold_reset <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      cycles     <= '0;
      tohost     <= TOHOST_DEFAULT;
      tohost_val <= '0;
      rst_cnt    <= '0;
      dram_base  <= '0;
      entry_pc   <= '0;
      RDATA      <= '0;
    end else begin
      state      <= state_nxt;
      core_rst_n <= (state_nxt == ST_RUN);
      hold_reset <= hold_nxt;
      rst_cnt    <= (state == ST_RSTSTR) ? rst_cnt + 16'd1 : '0;

      if (enter_rststr) begin
        cycles     <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
        tohost_val <= '0;
      end else if (state == ST_RUN) begin
        if (cycles != '1) cycles <= cycles + 32'd1;
        if (tohost_hit && !hold_set) begin
          tohost_val <= mon_wdata;
          done       <= 1'b1;
          pass       <= (mon_wdata == 32'd1);
        end
      end

      // Boot configuration is frozen while the core is coming up or running.
      if (wr_hit && !cfg_locked) begin
        unique case (wr_sel)
          REG_DRAMBASE: dram_base <= byte_merge(dram_base, WDATA, BYTEEN);
          REG_ENTRYPC:  entry_pc  <= byte_merge(entry_pc,  WDATA, BYTEEN);
          REG_TOHOST:   tohost    <= byte_merge(tohost,    WDATA, BYTEEN);
          default: ;
        endcase
      end

      if (RDEN) RDATA <= rd_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      unique case (rd_sel)
        REG_STATUS:     rd_data = {24'd0, 2'b00, state, pass, done,
                                   (state == ST_HOLD), (state == ST_RUN)};
        REG_CTRL:       rd_data = {31'd0, hold_reset};
        REG_DRAMBASE:   rd_data = dram_base;
        REG_ENTRYPC:    rd_data = entry_pc;
        REG_CYCLES:     rd_data = cycles;
        REG_TOHOST:     rd_data = tohost;
        REG_TOHOST_VAL: rd_data = tohost_val;
        default:        rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ctrl_regs.sv
// Scoreboard bench for boot_ctrl_regs: directed boot/run scenarios followed by
// randomized register and tohost traffic, checked against a behavioural model.
module tb_boot_ctrl_regs;

  localparam int BASE_I     = 'h1000;
  localparam int RST_CYC    = 16;
  localparam int PH_HOLD    = 0;
  localparam int PH_RSTSTR  = 1;
  localparam int PH_RUN     = 2;
  localparam int PH_FIN     = 3;

  localparam logic [15:0] A_STATUS = 16'h1000;
  localparam logic [15:0] A_CTRL   = 16'h1004;
  localparam logic [15:0] A_DRAM   = 16'h1008;
  localparam logic [15:0] A_ENTRY  = 16'h100C;
  localparam logic [15:0] A_CYCLES = 16'h1010;
  localparam logic [15:0] A_TOHOST = 16'h1014;
  localparam logic [15:0] A_TVAL   = 16'h1018;

  logic        ACLK, ARESETN;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic        WREN, RDEN;
  logic [31:0] WDATA, RDATA;
  logic        mon_wvalid;
  logic [31:0] mon_waddr, mon_wdata;
  logic        core_rst_n;
  logic [31:0] dram_base, entry_pc;

  boot_ctrl_regs #(.BASE(16'h1000), .RST_CYCLES(RST_CYC), .TOHOST_DEFAULT(32'h0000_1000)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN),
    .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .mon_wvalid(mon_wvalid), .mon_waddr(mon_waddr), .mon_wdata(mon_wdata),
    .core_rst_n(core_rst_n), .dram_base(dram_base), .entry_pc(entry_pc)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_phase, m_rst_left;
  bit          m_hold, m_done, m_pass;
  logic [31:0] m_dram, m_entry, m_tohost, m_tval, m_cycles;

  task automatic model_reset();
    m_phase = PH_HOLD; m_rst_left = 0;
    m_hold = 1'b1; m_done = 1'b0; m_pass = 1'b0;
    m_dram = '0; m_entry = '0; m_tohost = 32'h0000_1000; m_tval = '0; m_cycles = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    int off;
    off = int'(a) - BASE_I;
    if (off < 0 || off >= 32 || (off % 4) != 0) return 32'h0;
    case (off / 4)
      0: return 32'(m_phase * 16 + (m_pass ? 8 : 0) + (m_done ? 4 : 0) +
                    (m_phase == PH_HOLD ? 2 : 0) + (m_phase == PH_RUN ? 1 : 0));
      1: return {31'd0, m_hold};
      2: return m_dram;
      3: return m_entry;
      4: return m_cycles;
      5: return m_tohost;
      6: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int off, r;
    bit mapped, ctrl_b0, holdset, start, new_hold, locked, hit;
    if (!ARESETN) begin
      model_reset();
      return;
    end
    off      = int'(WRADDR) - BASE_I;
    mapped   = WREN && off >= 0 && off < 32 && (off % 4) == 0;
    r        = off / 4;
    ctrl_b0  = mapped && r == 1 && BYTEEN[0];
    holdset  = ctrl_b0 && WDATA[0];
    start    = ctrl_b0 && WDATA[1];
    new_hold = ctrl_b0 ? WDATA[0] : m_hold;
    locked   = (m_phase == PH_RSTSTR) || (m_phase == PH_RUN);
    hit      = (m_phase == PH_RUN) && mon_wvalid && (mon_waddr == m_tohost) && mon_wdata[0];

    if (mapped && !locked) begin
      if (r == 2) m_dram   = merge(m_dram,   WDATA, BYTEEN);
      if (r == 3) m_entry  = merge(m_entry,  WDATA, BYTEEN);
      if (r == 5) m_tohost = merge(m_tohost, WDATA, BYTEEN);
    end
    if (m_phase == PH_RUN && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;

    if (holdset) m_phase = PH_HOLD;
    else if ((m_phase == PH_HOLD || m_phase == PH_FIN) && start && !new_hold) begin
      m_phase = PH_RSTSTR; m_rst_left = RST_CYC;
      m_cycles = '0; m_done = 1'b0; m_pass = 1'b0; m_tval = '0;
    end else if (m_phase == PH_RSTSTR) begin
      m_rst_left--;
      if (m_rst_left == 0) m_phase = PH_RUN;
    end else if (m_phase == PH_RUN && hit) begin
      m_tval = mon_wdata; m_done = 1'b1; m_pass = (mon_wdata == 32'd1);
      m_phase = PH_FIN;
    end
    m_hold = new_hold;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    WREN = 1'b0; RDEN = 1'b0; mon_wvalid = 1'b0;
    WRADDR = '0; RDADDR = '0; BYTEEN = '0; WDATA = '0;
    mon_waddr = '0; mon_wdata = '0;
  endtask

  // One clock: queue the read expectation, let the edge happen, update the model,
  // then compare the directly observable outputs.
  task automatic tick();
    if (RDEN && ARESETN) sb_q.push_back('{addr: RDADDR, exp: model_read(RDADDR)});
    @(posedge ACLK);
    model_edge();
    @(negedge ACLK);
    check("core_rst_n", {31'd0, core_rst_n}, {31'd0, m_phase == PH_RUN});
    check("dram_base", dram_base, m_dram);
    check("entry_pc", entry_pc, m_entry);
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WREN = 1'b1; WRADDR = a; BYTEEN = be; WDATA = d;
    tick();
  endtask

  task automatic rd(input logic [15:0] a);
    RDEN = 1'b1; RDADDR = a;
    tick();
  endtask

  task automatic wr_rd(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d, input logic [15:0] ra);
    WREN = 1'b1; WRADDR = a; BYTEEN = be; WDATA = d;
    RDEN = 1'b1; RDADDR = ra;
    tick();
  endtask

  task automatic mon(input logic [31:0] a, input logic [31:0] d);
    mon_wvalid = 1'b1; mon_waddr = a; mon_wdata = d;
    tick();
  endtask

  task automatic wr_mon(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d,
                        input logic [31:0] ma, input logic [31:0] md);
    WREN = 1'b1; WRADDR = a; BYTEEN = be; WDATA = d;
    mon_wvalid = 1'b1; mon_waddr = ma; mon_wdata = md;
    tick();
  endtask

  task automatic pulse_reset();
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
  endtask

  function automatic logic [15:0] pick_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8) return 16'(BASE_I + 4 * k);
    if (k == 8) return 16'(BASE_I + 32 + 4 * $urandom_range(0, 7));
    return 16'(BASE_I + $urandom_range(0, 31));
  endfunction

  // ---------------- read monitor ----------------
  initial begin
    bit      rd_seen;
    rd_exp_t e;
    forever begin
      @(posedge ACLK);
      rd_seen = RDEN && ARESETN;
      @(negedge ACLK);
      if (rd_seen) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check($sformatf("read@%h", e.addr), RDATA, e.exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  be;
    logic [15:0] a;
    logic [31:0] d;

    set_idle();
    model_reset();
    ARESETN = 1'b0;
    idle(2);
    ARESETN = 1'b1;
    check("rdata_reset", RDATA, 32'h0);
    rd(A_STATUS); rd(A_CTRL); rd(A_TOHOST);

    // Configure and boot.
    wr(A_DRAM, 4'hF, 32'h2000_0000);
    wr(A_ENTRY, 4'hF, 32'h0);
    wr(A_CTRL, 4'h1, 32'h2);
    idle(RST_CYC + 4);
    rd(A_STATUS); rd(A_DRAM);

    // Passing tohost store.
    mon(32'h1000, 32'h1);
    rd(A_STATUS); rd(A_TVAL); rd(A_CYCLES); rd(A_CTRL);

    // Restart from FIN, failing tohost store.
    wr(A_CTRL, 4'h1, 32'h2);
    idle(RST_CYC + 3);
    mon(32'h1000, 32'h7);
    rd(A_STATUS); rd(A_TVAL); rd(A_CYCLES);

    // Locked config, ignored START and non-terminating stores while running.
    wr(A_CTRL, 4'h1, 32'h2);
    rd(A_STATUS);
    idle(RST_CYC);
    wr(A_DRAM, 4'hF, 32'hDEAD_BEEF);
    wr(A_TOHOST, 4'hF, 32'h0000_2000);
    wr(A_CTRL, 4'h1, 32'h2);
    rd(A_DRAM); rd(A_TOHOST);
    mon(32'h1000, 32'h2);
    mon(32'h1004, 32'h1);
    rd(A_STATUS); rd(A_TVAL);

    // Back to HOLD, byte-lane write, START suppressed by HOLD_RESET.
    wr(A_CTRL, 4'h1, 32'h1);
    rd(A_STATUS);
    wr(A_DRAM, 4'b0100, 32'h00AB_0000);
    wr(A_ENTRY, 4'b1001, 32'h8000_0044);
    rd(A_DRAM); rd(A_ENTRY);
    wr(A_CTRL, 4'h1, 32'h3);
    rd(A_STATUS); rd(A_CTRL);
    wr(A_CTRL, 4'hE, 32'h2);
    rd(A_STATUS);

    // HOLD_RESET beats a coincident tohost hit.
    wr(A_CTRL, 4'h1, 32'h2);
    idle(RST_CYC + 2);
    wr_mon(A_CTRL, 4'h1, 32'h1, 32'h1000, 32'h1);
    rd(A_STATUS); rd(A_TVAL);

    // Read-during-write returns old data; unmapped accesses.
    wr_rd(A_DRAM, 4'hF, 32'h1234_5678, A_DRAM);
    rd(A_DRAM);
    wr(16'h1020, 4'hF, 32'hFFFF_FFFF);
    wr(16'h101C, 4'hF, 32'hFFFF_FFFF);
    rd(16'h101C); rd(16'h1020); rd(16'h0FFC); rd(16'h1002);

    // Mid-run reset, then a clean boot.
    wr(A_CTRL, 4'h1, 32'h0);
    wr(A_CTRL, 4'h1, 32'h2);
    idle(RST_CYC + 5);
    rd(A_STATUS);
    pulse_reset();
    check("rdata_midrun_reset", RDATA, 32'h0);
    rd(A_STATUS); rd(A_CTRL); rd(A_DRAM); rd(A_TOHOST); rd(A_CYCLES);
    wr(A_CTRL, 4'h1, 32'h2);
    idle(RST_CYC + 6);
    mon(32'h1000, 32'h1);
    rd(A_STATUS); rd(A_CYCLES);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        a = pick_addr();
        if (a == A_CTRL) begin
          case ($urandom_range(0, 5))
            0, 1, 2: d = 32'h2;
            3:       d = 32'h0;
            4:       d = 32'h1;
            default: d = 32'h3;
          endcase
          be = 4'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 4'b0001 : 4'b0000);
        end else begin
          d  = $urandom;
          be = 4'($urandom_range(0, 15));
        end
        WREN = 1'b1; WRADDR = a; BYTEEN = be; WDATA = d;
      end
      if ($urandom_range(0, 3) == 0) begin
        RDEN = 1'b1; RDADDR = pick_addr();
      end
      if ($urandom_range(0, 7) == 0) begin
        mon_wvalid = 1'b1;
        mon_waddr  = ($urandom_range(0, 1) == 1) ? m_tohost : {$urandom, 2'b00} >> 2 << 2;
        mon_wdata  = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
      end
      ARESETN = ($urandom_range(0, 499) != 0);
      tick();
      ARESETN = 1'b1;
    end

    idle(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
